// File: rtl/fir_pkg.sv
// Shared constants for the FIR control slave: register map, ap_ctrl bit positions, FSM encodings.
package fir_pkg;

   localparam logic [11:0] AP_CTRL  = 12'h000;
   localparam logic [11:0] DATA_LEN = 12'h010;
   localparam logic [11:0] TAP_NUM  = 12'h014;
   localparam logic [11:0] TAP_BASE = 12'h020;

   localparam int AP_START_BIT = 0;
   localparam int AP_DONE_BIT  = 1;
   localparam int AP_IDLE_BIT  = 2;

   localparam logic [0:0] W_IDLE = 1'b0;
   localparam logic [0:0] W_ACK  = 1'b1;

   localparam logic [1:0] R_IDLE = 2'd0;
   localparam logic [1:0] R_ADDR = 2'd1;
   localparam logic [1:0] R_WAIT = 2'd2;
   localparam logic [1:0] R_DATA = 2'd3;

   localparam logic [31:0] BUSY_RDATA = 32'hFFFF_FFFF;

endpackage

// File: rtl/fir_axil_ctrl_if.sv
// AXI-Lite channel bundle between the host and the FIR control slave.
interface fir_axil_ctrl_if #(
   parameter int AW = 12,
   parameter int DW = 32
) ();
   logic          awvalid;
   logic          awready;
   logic [AW-1:0] awaddr;
   logic          wvalid;
   logic          wready;
   logic [DW-1:0] wdata;
   logic          arvalid;
   logic          arready;
   logic [AW-1:0] araddr;
   logic          rvalid;
   logic          rready;
   logic [DW-1:0] rdata;

   modport master (
      output awvalid, awaddr, wvalid, wdata, arvalid, araddr, rready,
      input  awready, wready, arready, rvalid, rdata
   );

   modport slave (
      input  awvalid, awaddr, wvalid, wdata, arvalid, araddr, rready,
      output awready, wready, arready, rvalid, rdata
   );
endinterface

// File: rtl/fir_tap_arb.sv
// Tap BRAM port mux: engine owns the port while busy, otherwise an AXI write beats an AXI read.
// Combinational port drive; rd_busy records who owned the port when the last read was issued.
module fir_tap_arb #(
   parameter int AW = 12,
   parameter int DW = 32,
   parameter logic [AW-1:0] BASE = 12'h020
)(
   input  logic          clk,
   input  logic          rst,
   input  logic          ap_idle,
   input  logic          wr_req,
   input  logic [AW-1:0] wr_addr,
   input  logic [DW-1:0] wr_data,
   input  logic          rd_issue,
   input  logic          rd_tap,
   input  logic [AW-1:0] rd_addr,
   input  logic [AW-1:0] eng_addr,
   output logic [3:0]    tap_WE,
   output logic          tap_EN,
   output logic [DW-1:0] tap_Di,
   output logic [AW-1:0] tap_A,
   output logic          rd_busy
);
   assign tap_EN = 1'b1;

   always_comb begin
      tap_WE = 4'h0;
      tap_Di = '0;
      tap_A  = '0;
      if (!ap_idle) begin
         tap_A = eng_addr;
      end else if (wr_req) begin
         tap_WE = 4'hF;
         tap_A  = wr_addr - BASE;
         tap_Di = wr_data;
      end else if (rd_issue && rd_tap) begin
         tap_A = rd_addr - BASE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         rd_busy <= 1'b0;
      else if (rd_issue)
         rd_busy <= !ap_idle;
   end
endmodule

// File: rtl/fir_axil_ctrl.sv
// AXI-Lite control slave for the FIR engine: ap_ctrl, data_length, tap_num and the tap BRAM window.
// Write acks one cycle after aw+w valid; rvalid 3 cycles after arvalid, held until rready.
module fir_axil_ctrl
   import fir_pkg::*;
#(
   parameter int pADDR_WIDTH = 12,
   parameter int pDATA_WIDTH = 32,
   parameter int Tape_Num    = 11,
   parameter logic [pADDR_WIDTH-1:0] pTAP_BASE = pADDR_WIDTH'(TAP_BASE)
)(
   input  logic                   axis_clk,
   input  logic                   axis_rst,
   fir_axil_ctrl_if.slave         axil,
   output logic [3:0]             tap_WE,
   output logic                   tap_EN,
   output logic [pDATA_WIDTH-1:0] tap_Di,
   output logic [pADDR_WIDTH-1:0] tap_A,
   input  logic [pDATA_WIDTH-1:0] tap_Do,
   input  logic [pADDR_WIDTH-1:0] eng_tap_A,
   output logic                   ap_start_o,
   input  logic                   eng_done,
   output logic [pDATA_WIDTH-1:0] data_length,
   output logic [pDATA_WIDTH-1:0] tap_num
);
   localparam logic [pADDR_WIDTH-1:0] A_CTRL   = pADDR_WIDTH'(AP_CTRL);
   localparam logic [pADDR_WIDTH-1:0] A_LEN    = pADDR_WIDTH'(DATA_LEN);
   localparam logic [pADDR_WIDTH-1:0] A_TAPN   = pADDR_WIDTH'(TAP_NUM);
   localparam logic [pADDR_WIDTH-1:0] TAP_LAST = pTAP_BASE + pADDR_WIDTH'(4 * Tape_Num - 4);
   localparam logic [pDATA_WIDTH-1:0] TAP_MAX  = pDATA_WIDTH'(Tape_Num);

   function automatic logic in_tap(input logic [pADDR_WIDTH-1:0] a);
      return (a >= pTAP_BASE) && (a <= TAP_LAST) && (a[1:0] == 2'b00);
   endfunction

   logic [0:0]             w_state;
   logic [pADDR_WIDTH-1:0] w_addr;
   logic [pDATA_WIDTH-1:0] w_data;
   logic [1:0]             r_state;
   logic [pADDR_WIDTH-1:0] r_addr;
   logic [pDATA_WIDTH-1:0] rd_val;
   logic                   ap_done, ap_idle, rd_busy;
   logic                   w_fire, r_issue, r_tap;

   assign w_fire       = (w_state == W_ACK);
   assign axil.awready = w_fire;
   assign axil.wready  = w_fire;
   // A write ack cycle owns the BRAM; the read address phase simply stretches by one.
   assign r_issue      = (r_state == R_ADDR) && !w_fire;
   assign axil.arready = r_issue;
   assign axil.rvalid  = (r_state == R_DATA);
   assign r_tap        = in_tap(r_addr);

   always_ff @(posedge axis_clk) begin
      if (axis_rst) begin
         w_state <= W_IDLE;
         w_addr  <= '0;
         w_data  <= '0;
      end else begin
         case (w_state)
            W_IDLE: if (axil.awvalid && axil.wvalid) begin
               w_state <= W_ACK;
               w_addr  <= axil.awaddr;
               w_data  <= axil.wdata;
            end
            default: w_state <= W_IDLE;
         endcase
      end
   end

   always_comb begin
      rd_val = '0;
      if (r_tap) begin
         rd_val = rd_busy ? pDATA_WIDTH'(BUSY_RDATA) : tap_Do;
      end else begin
         case (r_addr)
            A_CTRL: begin
               rd_val[AP_DONE_BIT] = ap_done;
               rd_val[AP_IDLE_BIT] = ap_idle;
            end
            A_LEN:   rd_val = data_length;
            A_TAPN:  rd_val = tap_num;
            default: rd_val = '0;
         endcase
      end
   end

   always_ff @(posedge axis_clk) begin
      if (axis_rst) begin
         r_state    <= R_IDLE;
         r_addr     <= '0;
         axil.rdata <= '0;
      end else begin
         case (r_state)
            R_IDLE: if (axil.arvalid) begin
               r_state <= R_ADDR;
               r_addr  <= axil.araddr;
            end
            R_ADDR: if (r_issue) r_state <= R_WAIT;
            R_WAIT: begin
               r_state    <= R_DATA;
               axil.rdata <= rd_val;
            end
            R_DATA: if (axil.rready) r_state <= R_IDLE;
         endcase
      end
   end

   always_ff @(posedge axis_clk) begin
      if (axis_rst) begin
         ap_start_o  <= 1'b0;
         ap_done     <= 1'b0;
         ap_idle     <= 1'b1;
         data_length <= '0;
         tap_num     <= TAP_MAX;
      end else begin
         ap_start_o <= 1'b0;
         if (r_state == R_WAIT && r_addr == A_CTRL)
            ap_done <= 1'b0;
         if (w_fire && ap_idle) begin
            case (w_addr)
               A_CTRL: if (w_data[AP_START_BIT]) begin
                  ap_start_o <= 1'b1;
                  ap_idle    <= 1'b0;
                  ap_done    <= 1'b0;
               end
               A_LEN:   data_length <= w_data;
               A_TAPN:  tap_num <= (w_data > TAP_MAX) ? TAP_MAX : w_data;
               default: ;
            endcase
         end
         // Done is applied last so it wins over a same-cycle clear-on-read.
         if (eng_done) begin
            ap_done <= 1'b1;
            ap_idle <= 1'b1;
         end
      end
   end

   fir_tap_arb #(
      .AW   (pADDR_WIDTH),
      .DW   (pDATA_WIDTH),
      .BASE (pTAP_BASE)
   ) u_tap_arb (
      .clk      (axis_clk),
      .rst      (axis_rst),
      .ap_idle  (ap_idle),
      .wr_req   (w_fire && in_tap(w_addr) && !axis_rst),
      .wr_addr  (w_addr),
      .wr_data  (w_data),
      .rd_issue (r_issue),
      .rd_tap   (r_tap),
      .rd_addr  (r_addr),
      .eng_addr (eng_tap_A),
      .tap_WE   (tap_WE),
      .tap_EN   (tap_EN),
      .tap_Di   (tap_Di),
      .tap_A    (tap_A),
      .rd_busy  (rd_busy)
   );
endmodule

// File: tb/tb_fir_axil_ctrl.sv
// Directed bench for fir_axil_ctrl with a 1-cycle-latency tap BRAM model.
module tb_fir_axil_ctrl;
   logic        axis_clk = 1'b0;
   logic        axis_rst;
   logic [3:0]  tap_WE;
   logic        tap_EN;
   logic [31:0] tap_Di;
   logic [11:0] tap_A;
   logic [31:0] tap_Do;
   logic [11:0] eng_tap_A;
   logic        ap_start_o;
   logic        eng_done;
   logic [31:0] data_length;
   logic [31:0] tap_num;

   int n_tests = 0;
   int n_fail  = 0;

   fir_axil_ctrl_if #(.AW(12), .DW(32)) axil ();

   fir_axil_ctrl dut (
      .axis_clk    (axis_clk),
      .axis_rst    (axis_rst),
      .axil        (axil),
      .tap_WE      (tap_WE),
      .tap_EN      (tap_EN),
      .tap_Di      (tap_Di),
      .tap_A       (tap_A),
      .tap_Do      (tap_Do),
      .eng_tap_A   (eng_tap_A),
      .ap_start_o  (ap_start_o),
      .eng_done    (eng_done),
      .data_length (data_length),
      .tap_num     (tap_num)
   );

   always #5 axis_clk = ~axis_clk;

   logic [31:0] mem [0:15];
   always @(posedge axis_clk) begin
      if (axis_rst) begin
         for (int i = 0; i < 16; i++) mem[i] <= '0;
         tap_Do <= '0;
      end else if (tap_EN) begin
         for (int b = 0; b < 4; b++)
            if (tap_WE[b]) mem[tap_A[5:2]][8*b +: 8] <= tap_Di[8*b +: 8];
         tap_Do <= mem[tap_A[5:2]];
      end
   end

   typedef struct {
      bit          wr;
      logic [11:0] addr;
      logic [31:0] data;
      logic [31:0] exp;
   } vec_t;
   vec_t vecs[$];

   task automatic add(input bit wr, input logic [11:0] a, input logic [31:0] d, input logic [31:0] e);
      vec_t v;
      v.wr = wr; v.addr = a; v.data = d; v.exp = e;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic axi_write(input logic [11:0] a, input logic [31:0] d, output int ack, output logic [3:0] we);
      axil.awaddr = a; axil.wdata = d;
      axil.awvalid = 1'b1; axil.wvalid = 1'b1;
      ack = 0;
      do begin
         @(posedge axis_clk); #1;
         ack++;
      end while (!(axil.awready && axil.wready) && ack < 20);
      we = tap_WE;
      @(posedge axis_clk); #1;
      axil.awvalid = 1'b0; axil.wvalid = 1'b0;
   endtask

   task automatic axi_read(input logic [11:0] a, output logic [31:0] d, output int lat);
      bit got_ar = 1'b0;
      axil.araddr = a; axil.arvalid = 1'b1;
      lat = 0;
      while (!axil.rvalid && lat < 20) begin
         @(posedge axis_clk); #1;
         lat++;
         if (got_ar) axil.arvalid = 1'b0;
         if (axil.arready) got_ar = 1'b1;
      end
      axil.arvalid = 1'b0;
      d = axil.rdata;
      axil.rready = 1'b1;
      @(posedge axis_clk); #1;
      axil.rready = 1'b0;
   endtask

   int taps [11] = '{0, -10, -9, 23, 56, 63, 56, 23, -9, -10, 0};

   initial begin
      int          ack, lat;
      logic [3:0]  we;
      logic [31:0] rd;

      axil.awvalid = 0; axil.awaddr = '0; axil.wvalid = 0; axil.wdata = '0;
      axil.arvalid = 0; axil.araddr = '0; axil.rready = 0;
      eng_tap_A = '0; eng_done = 0; axis_rst = 1'b1;
      repeat (3) @(posedge axis_clk);
      #1;
      check("rst_handshake", {29'd0, axil.awready, axil.arready, axil.rvalid}, 32'd0);
      check("rst_rdata", axil.rdata, 32'd0);
      check("rst_tap_port", {27'd0, tap_WE, tap_EN}, 32'd1);
      check("rst_tap_A_Di", {8'd0, tap_A, tap_Di[11:0]}, 32'd0);
      check("rst_start", 32'(ap_start_o), 32'd0);
      check("rst_data_length", data_length, 32'd0);
      check("rst_tap_num", tap_num, 32'd11);
      axis_rst = 1'b0;
      @(posedge axis_clk); #1;
      axi_read(12'h000, rd, lat);
      check("rst_ap_ctrl", rd, 32'h4);

      for (int i = 0; i < 11; i++) add(1'b1, 12'h020 + 12'(4 * i), 32'(taps[i]), 32'd0);
      add(1'b1, 12'h026, 32'd55, 32'd0);
      add(1'b1, 12'h04C, 32'd99, 32'd0);
      for (int i = 0; i < 11; i++) add(1'b0, 12'h020 + 12'(4 * i), 32'd0, 32'(taps[i]));
      add(1'b0, 12'h04C, 32'd0, 32'd0);
      add(1'b0, 12'h026, 32'd0, 32'd0);
      add(1'b1, 12'h010, 32'd600, 32'd0);
      add(1'b1, 12'h014, 32'd3, 32'd0);
      add(1'b0, 12'h014, 32'd0, 32'd3);
      add(1'b1, 12'h014, 32'd20, 32'd0);
      add(1'b0, 12'h010, 32'd0, 32'd600);
      add(1'b0, 12'h014, 32'd0, 32'd11);
      add(1'b1, 12'h008, 32'd7, 32'd0);
      add(1'b0, 12'h008, 32'd0, 32'd0);

      foreach (vecs[i]) begin
         if (vecs[i].wr) begin
            axi_write(vecs[i].addr, vecs[i].data, ack, we);
            check($sformatf("wr_ack_cycles@%h", vecs[i].addr), 32'(ack), 32'd1);
         end else begin
            axi_read(vecs[i].addr, rd, lat);
            check($sformatf("rd_latency@%h", vecs[i].addr), 32'(lat), 32'd3);
            check($sformatf("rd_data@%h", vecs[i].addr), rd, vecs[i].exp);
         end
      end
      check("beyond_window_no_bram_write", mem[11], 32'd0);

      // Start pulse, then behaviour while the engine owns the BRAM.
      axi_write(12'h000, 32'd1, ack, we);
      check("start_pulse_hi", 32'(ap_start_o), 32'd1);
      @(posedge axis_clk); #1;
      check("start_pulse_lo", 32'(ap_start_o), 32'd0);
      axi_read(12'h000, rd, lat);
      check("busy_ap_ctrl", rd, 32'h0);
      axi_write(12'h000, 32'd1, ack, we);
      check("start_while_busy", 32'(ap_start_o), 32'd0);
      axi_write(12'h010, 32'd7, ack, we);
      check("busy_len_ignored", data_length, 32'd600);
      axi_write(12'h024, 32'd77, ack, we);
      check("busy_tap_WE", 32'(we), 32'd0);
      axi_read(12'h024, rd, lat);
      check("busy_tap_read", rd, 32'hFFFF_FFFF);
      eng_tap_A = 12'h008;
      @(posedge axis_clk); #1;
      check("busy_eng_tap_A", 32'(tap_A), 32'h008);
      eng_done = 1'b1;
      @(posedge axis_clk); #1;
      eng_done = 1'b0;
      axi_read(12'h000, rd, lat);
      check("done_ap_ctrl", rd, 32'h6);
      axi_read(12'h000, rd, lat);
      check("done_cleared", rd, 32'h4);
      axi_read(12'h024, rd, lat);
      check("busy_write_dropped", rd, 32'hFFFF_FFF6);

      // Write and read address phase land in the same cycle.
      axil.awaddr = 12'h028; axil.wdata = 32'd5; axil.araddr = 12'h02C;
      axil.awvalid = 1'b1; axil.wvalid = 1'b1; axil.arvalid = 1'b1;
      @(posedge axis_clk); #1;
      check("coincide_awready", 32'(axil.awready), 32'd1);
      check("coincide_arready_stall", 32'(axil.arready), 32'd0);
      @(posedge axis_clk); #1;
      axil.awvalid = 1'b0; axil.wvalid = 1'b0;
      check("coincide_arready_late", 32'(axil.arready), 32'd1);
      check("coincide_write_first", mem[2], 32'd5);
      @(posedge axis_clk); #1;
      axil.arvalid = 1'b0;
      for (int k = 0; k < 10 && !axil.rvalid; k++) begin
         @(posedge axis_clk); #1;
      end
      check("coincide_read_data", axil.rdata, 32'd23);
      axil.rready = 1'b1;
      @(posedge axis_clk); #1;
      axil.rready = 1'b0;
      axi_read(12'h028, rd, lat);
      check("coincide_tap_written", rd, 32'd5);

      // Reset while a read response is stalled on rready.
      axi_write(12'h014, 32'd5, ack, we);
      check("tap_num_pre_rst", tap_num, 32'd5);
      axil.araddr = 12'h010; axil.arvalid = 1'b1;
      for (int k = 0; k < 10 && !axil.rvalid; k++) begin
         @(posedge axis_clk); #1;
         if (k == 1) axil.arvalid = 1'b0;
      end
      axil.arvalid = 1'b0;
      @(posedge axis_clk); #1;
      check("rvalid_held", 32'(axil.rvalid), 32'd1);
      axis_rst = 1'b1;
      @(posedge axis_clk); #1;
      axis_rst = 1'b0;
      check("midrst_rvalid", 32'(axil.rvalid), 32'd0);
      check("midrst_tap_num", tap_num, 32'd11);
      check("midrst_data_length", data_length, 32'd0);
      axi_read(12'h000, rd, lat);
      check("midrst_ap_idle", rd, 32'h4);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, %0d tests run", n_tests);
      $fatal(1, "timeout");
   end
endmodule
